// File: rtl/codificador_de_imediato.sv
// codificador_de_imediato: range-checks an immediate and scatters it into RV32I I/S/B/U/J fields
module codificador_de_imediato #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      base_instr,
  input  logic [2:0]       ImmSel,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             erro,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [31:0]      base_q, base_d, imm_q, imm_d, instr_q, instr_d;
  logic [2:0]       sel_q, sel_d;
  logic             err1_q, err1_d, erro_q, erro_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d;
  logic             s1_advance, accept, emit;
  logic             ok_i, ok_b, ok_j, ok_u;
  logic [31:0]      mask, field, packed_w;
  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;
  assign emit       = s2_valid_q && out_ready;
  assign out_valid  = s2_valid_q;
  assign instr_out  = instr_q;
  assign erro       = erro_q;
  assign cnt_ok     = cnt_ok_q;
  assign cnt_err    = cnt_err_q;
  // stage 1: capture the offered word and decide whether the immediate fits its format
  always_comb begin
    ok_i       = imm == {{20{imm[11]}}, imm[11:0]};
    ok_b       = imm == {{19{imm[12]}}, imm[12:0]} && !imm[0];
    ok_j       = imm == {{11{imm[20]}}, imm[20:0]} && !imm[0];
    ok_u       = imm[11:0] == 12'd0;
    err1_d     = !accept ? err1_q :
                 (ImmSel == 3'd0 || ImmSel == 3'd1) ? !ok_i :
                 ImmSel == 3'd2 ? !ok_b :
                 ImmSel == 3'd3 ? !ok_u :
                 ImmSel == 3'd4 ? !ok_j : 1'b1;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    base_d     = accept ? base_instr : base_q;
    sel_d      = accept ? ImmSel : sel_q;
    imm_d      = accept ? imm : imm_q;
  end
  // stage 2: scatter immediate bits; an erroneous word gets its immediate slots cleared
  always_comb begin
    mask       = sel_q == 3'd0 ? 32'hFFF0_0000 :
                 (sel_q == 3'd1 || sel_q == 3'd2) ? 32'hFE00_0F80 :
                 (sel_q == 3'd3 || sel_q == 3'd4) ? 32'hFFFF_F000 : 32'h0;
    field      = sel_q == 3'd0 ? {imm_q[11:0], 20'd0} :
                 sel_q == 3'd1 ? {imm_q[11:5], 13'd0, imm_q[4:0], 7'd0} :
                 sel_q == 3'd2 ? {imm_q[12], imm_q[10:5], 13'd0, imm_q[4:1], imm_q[11], 7'd0} :
                 sel_q == 3'd3 ? {imm_q[31:12], 12'd0} :
                 sel_q == 3'd4 ? {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], 12'd0} : 32'h0;
    packed_w   = (base_q & ~mask) | (err1_q ? 32'h0 : field);
    s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
    instr_d    = (s1_advance && s1_valid_q) ? packed_w : instr_q;
    erro_d     = (s1_advance && s1_valid_q) ? err1_q : erro_q;
  end
  // saturating tallies of emitted words, split by error flag
  always_comb begin
    cnt_ok_d  = (emit && !erro_q && cnt_ok_q != '1) ? cnt_ok_q + CNT_W'(1) : cnt_ok_q;
    cnt_err_d = (emit && erro_q && cnt_err_q != '1) ? cnt_err_q + CNT_W'(1) : cnt_err_q;
  end
  // state registers with synchronous reset that drops any in-flight words
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      base_q     <= '0;
      sel_q      <= '0;
      imm_q      <= '0;
      err1_q     <= 1'b0;
      instr_q    <= '0;
      erro_q     <= 1'b0;
      cnt_ok_q   <= '0;
      cnt_err_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      base_q     <= base_d;
      sel_q      <= sel_d;
      imm_q      <= imm_d;
      err1_q     <= err1_d;
      instr_q    <= instr_d;
      erro_q     <= erro_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_err_q  <= cnt_err_d;
    end
  end
endmodule

// File: tb/tb_codificador_de_imediato.sv
// tb_codificador_de_imediato: directed and randomized checks of the immediate encoder pipeline
module tb_codificador_de_imediato;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] base_instr, imm;
  logic [2:0]  ImmSel;
  logic        in_ready, out_valid, erro;
  logic [31:0] instr_out;
  logic [15:0] cnt_ok, cnt_err;
  logic        in_ready2, out_valid2, erro2;
  logic [31:0] instr_out2;
  logic [1:0]  cnt_ok2, cnt_err2;
  int checks = 0, failures = 0, cyc = 0;
  int ok_m = 0, err_m = 0, accepts = 0, outs = 0;
  int last_acc_cyc = 0, last_out_cyc = 0, first_acc_cyc = 0;
  logic [32:0] q[$];
  logic [32:0] last_out, held;
  logic        stall_prev = 1'b0, acc;

  codificador_de_imediato #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .base_instr(base_instr), .ImmSel(ImmSel), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instr_out(instr_out), .erro(erro), .cnt_ok(cnt_ok), .cnt_err(cnt_err));

  codificador_de_imediato #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .base_instr(base_instr), .ImmSel(ImmSel), .imm(imm), .out_valid(out_valid2),
    .out_ready(out_ready), .instr_out(instr_out2), .erro(erro2), .cnt_ok(cnt_ok2), .cnt_err(cnt_err2));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // reference: range judged on the signed value, then fields placed by the format's layout
  function automatic logic [32:0] model(input logic [31:0] b, input logic [2:0] s, input logic [31:0] v);
    longint x;
    bit ok;
    logic [31:0] w;
    x = longint'($signed(v));
    w = b;
    case (s)
      3'd0, 3'd1: ok = x >= -2048 && x <= 2047;
      3'd2:       ok = x >= -4096 && x <= 4095 && x % 2 == 0;
      3'd3:       ok = (v % 4096) == 0;
      3'd4:       ok = x >= -(64'sd1 << 20) && x < (64'sd1 << 20) && x % 2 == 0;
      default:    ok = 0;
    endcase
    case (s)
      3'd0: w[31:20] = ok ? v[11:0] : 12'd0;
      3'd1: begin w[31:25] = ok ? v[11:5] : 7'd0; w[11:7] = ok ? v[4:0] : 5'd0; end
      3'd2: begin
        w[31] = ok & v[12]; w[30:25] = ok ? v[10:5] : 6'd0;
        w[11:8] = ok ? v[4:1] : 4'd0; w[7] = ok & v[11];
      end
      3'd3: w[31:12] = ok ? v[31:12] : 20'd0;
      3'd4: begin
        w[31] = ok & v[20]; w[30:21] = ok ? v[10:1] : 10'd0;
        w[20] = ok & v[11]; w[19:12] = ok ? v[19:12] : 8'd0;
      end
      default: ;
    endcase
    return {!ok, w};
  endfunction

  function automatic logic [31:0] gen_good(input logic [2:0] s);
    int r;
    case (s)
      3'd0, 3'd1: r = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       r = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd3:       r = int'($urandom & 32'hFFFF_F000);
      3'd4:       r = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default:    r = int'($urandom);
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge, score handshakes, then advance past the next posedge
  task automatic tick();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (stall_prev) chk("hold", {31'd0, erro, instr_out}, {31'd0, held});
    stall_prev = out_valid && !out_ready;
    held = {erro, instr_out};
    if (out_valid && out_ready) begin
      outs++;
      last_out_cyc = cyc;
      last_out = {erro, instr_out};
      if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else begin
        logic [32:0] e;
        e = q.pop_front();
        chk("word", {31'd0, erro, instr_out}, {31'd0, e});
        if (e[32]) err_m++; else ok_m++;
      end
    end
    if (acc) begin
      if (accepts == 0) first_acc_cyc = cyc;
      accepts++;
      last_acc_cyc = cyc;
      q.push_back(model(base_instr, ImmSel, imm));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    ok_m = 0; err_m = 0; accepts = 0; outs = 0;
    stall_prev = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] b, input logic [31:0] v);
    in_valid = 1'b1; ImmSel = s; base_instr = b; imm = v;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    chk("send_accepted", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic dir(input string tag, input logic [2:0] s, input logic [31:0] b,
                     input logic [31:0] v, input logic [31:0] ei, input logic ee);
    send(s, b, v);
    drain();
    chk(tag, {31'd0, last_out}, {31'd0, ee, ei});
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_ok"}, 64'(cnt_ok), 64'(ok_m));
    chk({tag, "_err"}, 64'(cnt_err), 64'(err_m));
    chk({tag, "_ok2"}, 64'(cnt_ok2), 64'(ok_m > 3 ? 3 : ok_m));
    chk({tag, "_err2"}, 64'(cnt_err2), 64'(err_m > 3 ? 3 : err_m));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    base_instr = '0; imm = '0; ImmSel = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out", {31'd0, out_valid, erro, instr_out}, 64'd0);
    chk_counts("rst");

    dir("I_neg1", 3'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    chk("latency", 64'(last_out_cyc - last_acc_cyc), 64'd2);
    chk("cnt_ok_1", 64'(cnt_ok), 64'd1);
    dir("S_8", 3'd1, 32'h0000_2023, 32'd8, 32'h0000_2423, 1'b0);
    dir("B_m4", 3'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    dir("J_800", 3'd4, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0);
    dir("U_up", 3'd3, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    dir("I_range", 3'd0, 32'h0000_0013, 32'h0000_0800, 32'h0000_0013, 1'b1);
    dir("B_odd", 3'd2, 32'h0000_0063, 32'd3, 32'h0000_0063, 1'b1);
    dir("U_low", 3'd3, 32'h0000_0037, 32'h0000_1001, 32'h0000_0037, 1'b1);
    dir("bad_sel", 3'd5, 32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1);
    chk("cnt_err_4", 64'(cnt_err), 64'd4);
    chk_counts("dir");

    out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; ImmSel = 3'd0; base_instr = 32'h13 + 32'(i << 7); imm = 32'(i + 1);
      tick();
    end
    chk("bp_accepts", 64'(accepts), 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_stalled_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    outs = 0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_drain_rate", 64'(outs), 64'd3);
    drain();
    chk_counts("bp");

    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 4));
      in_valid = 1'b1; ImmSel = s; base_instr = $urandom; imm = gen_good(s);
      tick();
    end
    in_valid = 1'b0;
    chk("stream_accepts", 64'(accepts), 64'd100);
    for (int i = 0; i < 20 && outs < 100; i++) tick();
    chk("stream_outs", 64'(outs), 64'd100);
    chk("stream_span", 64'(last_out_cyc - first_acc_cyc), 64'd101);
    chk("stream_cnt_ok", 64'(cnt_ok), 64'd100);
    chk("stream_sat", 64'(cnt_ok2), 64'd3);
    chk_counts("stream");

    out_ready = 1'b0;
    send(3'd0, 32'h13, 32'd5);
    send(3'd1, 32'h2023, 32'd6);
    do_reset();
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk_counts("midrst");
    out_ready = 1'b1;
    dir("post_rst", 3'd0, 32'h0000_0093, 32'h0000_07FF, 32'h7FF0_0093, 1'b0);
    chk("five_a", 64'(cnt_ok), 64'd1);
    for (int i = 0; i < 4; i++) send(3'd3, 32'h37, 32'(i) << 12);
    drain();
    chk("five_ok", 64'(cnt_ok), 64'd5);
    chk("five_sat2", 64'(cnt_ok2), 64'd3);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      ImmSel = s;
      base_instr = $urandom;
      case ($urandom_range(0, 3))
        0: imm = gen_good(s);
        1: imm = $urandom;
        2: imm = 32'($urandom_range(0, 16));
        default: imm = gen_good(s) + 32'd1;
      endcase
      tick();
    end
    out_ready = 1'b1;
    drain();
    chk_counts("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
